// File: rtl/aes_inv_pkg.sv
// aes_inv_pkg: shared types, inverse S-box and GF(2^8) helpers for the AES-128 inverse cipher.
package aes_inv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NR = 10;
  // Byte 0 of the table sits in the top bits.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  localparam logic [15:0] IMC_COEF = 16'hebd9;
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[8*(255-int'(x)) +: 8];
  endfunction
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      p = b[i] ? p ^ t : p;
      t = gf_xtime(t);
    end
    return p;
  endfunction
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc ^= gf_mul(s[127-8*(k+4*c) -: 8], IMC_COEF[15-4*((k-r+4)%4) -: 4]);
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round, InvShiftRows/InvSubBytes/AddRoundKey then InvMixColumns unless last.
module aes_inv_round import aes_inv_pkg::*; (
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_nxt
);
  logic [127:0] sr, sb, ark;
  assign sr = inv_shift_rows(st);
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[8*i +: 8] = inv_sbox(sr[8*i +: 8]);
  end
  assign ark = sb ^ rk;
  assign st_nxt = last ? ark : inv_mix_columns(ark);
endmodule

// File: rtl/aes128_inv_cipher.sv
// aes128_inv_cipher: iterative AES-128 decryptor, one inverse round per clock with valid/ready handshakes.
module aes128_inv_cipher import aes_inv_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);
  state_t state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [127:0] st_q, st_d, rnd_out;
  aes_inv_round u_round (.st(st_q), .rk(key_in), .last(rnd_q == 4'd0), .st_nxt(rnd_out));
  always_comb begin
    state_d = state_q;
    rnd_d = rnd_q;
    st_d = st_q;
    key_idx = state_q == IDLE ? 4'(NR) : state_q == RUN ? rnd_q : 4'd0;
    if (state_q == IDLE && in_valid) begin
      st_d = din ^ key_in;
      rnd_d = 4'(NR - 1);
      state_d = RUN;
    end
    if (state_q == RUN) begin
      st_d = rnd_out;
      rnd_d = rnd_q == 4'd0 ? 4'd0 : rnd_q - 4'd1;
      state_d = rnd_q == 4'd0 ? DONE : RUN;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rnd_q <= '0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      rnd_q <= rnd_d;
      st_q <= st_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign dout = st_q;
endmodule
